// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and widths for the wishbone RAM slave
//
// Holds the slave FSM state encoding, the wishbone data/select widths and
// the width of the wait-state counter (WAIT_STATES legal range 0..15).
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;
  localparam int WB_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_ram_array.sv
// rtl/wb_ram_array.sv - single-port synchronous RAM with per-byte write enables
//
// Ports:
//   clk    - clock
//   en     - access enable; one access per enabled edge
//   wr     - 1 = write (lanes selected by be), 0 = read into rdata
//   be     - byte-lane write enables, bit k covers wdata[8k+7:8k]
//   addr   - word address
//   wdata  - write data
//   rdata  - registered read data; holds the last read word, untouched by writes
module wb_ram_array
  import wb_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 wr,
  input  logic [WB_SEL_W-1:0]  be,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [WB_DATA_W-1:0] wdata,
  output logic [WB_DATA_W-1:0] rdata
);

  logic [WB_DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (wr) begin
        for (int k = 0; k < WB_SEL_W; k++) begin
          if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/wb_slave_ram.sv
// rtl/wb_slave_ram.sv - wishbone classic slave RAM with programmable wait states
//
// Word-addressed, byte-lane-writable RAM behind a wishbone classic slave port.
// A request (stb & cyc) is captured in IDLE, counted down through WAIT_STATES
// idle cycles, and acknowledged with a single-cycle ack. Dropping cyc during
// the countdown aborts the access without writing or acking.
//
// Parameters: ADDR_W (word-address bits), WAIT_STATES (0..15).
// Optional build macro: WBRAM_READ_REG_EN adds an output register on read
// data, delaying read acks by one cycle; write timing is unchanged.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   wishbone_addr_i  - byte address; bits [ADDR_W+1:2] select the word
//   wishbone_data_i  - write data
//   wishbone_we_i    - 1 = write, 0 = read
//   wishbone_sel_i   - byte-lane enables
//   wishbone_stb_i   - strobe
//   wishbone_cyc_i   - bus cycle valid
//   wishbone_data_o  - read data, zero whenever ack is low
//   wishbone_ack_o   - single-cycle acknowledge
module wb_slave_ram
  import wb_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          wishbone_addr_i,
  input  logic [WB_DATA_W-1:0] wishbone_data_i,
  input  logic                 wishbone_we_i,
  input  logic [WB_SEL_W-1:0]  wishbone_sel_i,
  input  logic                 wishbone_stb_i,
  input  logic                 wishbone_cyc_i,
  output logic [WB_DATA_W-1:0] wishbone_data_o,
  output logic                 wishbone_ack_o
);

  localparam logic [WB_CNT_W-1:0] WAIT_LOAD = WB_CNT_W'(WAIT_STATES);
  localparam logic [WB_CNT_W-1:0] CNT_ONE   = WB_CNT_W'(1);

  wb_state_t             state;
  logic [WB_CNT_W-1:0]   wait_cnt;
  logic [ADDR_W-1:0]     cap_addr;
  logic [WB_DATA_W-1:0]  cap_data;
  logic                  cap_we;
  logic [WB_SEL_W-1:0]   cap_sel;
  logic                  ack_q;

  logic                  req;
  logic                  ram_en;
  logic                  ram_wr;
  logic [WB_SEL_W-1:0]   ram_sel;
  logic [ADDR_W-1:0]     ram_addr;
  logic [WB_DATA_W-1:0]  ram_wdata;
  logic [WB_DATA_W-1:0]  ram_rdata;

  // Only the word-index bits of the byte address matter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wishbone_addr_i[31:ADDR_W+2], wishbone_addr_i[1:0]};

  assign req = wishbone_stb_i & wishbone_cyc_i;

  // The RAM is accessed on exactly the edge that enters ACK. With zero wait
  // states that is the capture edge itself, so the live bus values are used
  // there; otherwise the captured copy drives the access.
  always_comb begin
    ram_en    = 1'b0;
    ram_wr    = cap_we;
    ram_sel   = cap_sel;
    ram_addr  = cap_addr;
    ram_wdata = cap_data;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (req && WAIT_STATES == 0) begin
            ram_en    = 1'b1;
            ram_wr    = wishbone_we_i;
            ram_sel   = wishbone_sel_i;
            ram_addr  = wishbone_addr_i[ADDR_W+1:2];
            ram_wdata = wishbone_data_i;
          end
        end
        ST_WAIT: begin
          if (wishbone_cyc_i && wait_cnt == CNT_ONE) ram_en = 1'b1;
        end
        default: ;
      endcase
    end
  end

  wb_ram_array #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .wr    (ram_wr),
    .be    (ram_wr ? ram_sel : '0),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

`ifdef WBRAM_READ_REG_EN
  logic                 rd_pend;
  logic [WB_DATA_W-1:0] data_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      ack_q    <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
      cap_we   <= 1'b0;
      cap_sel  <= '0;
`ifdef WBRAM_READ_REG_EN
      rd_pend  <= 1'b0;
      data_q   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            cap_addr <= wishbone_addr_i[ADDR_W+1:2];
            cap_data <= wishbone_data_i;
            cap_we   <= wishbone_we_i;
            cap_sel  <= wishbone_sel_i;
            wait_cnt <= WAIT_LOAD;
            state    <= (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!wishbone_cyc_i) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_ONE) begin
            state    <= ST_ACK;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt - CNT_ONE;
          end
        end
        ST_ACK: begin
`ifdef WBRAM_READ_REG_EN
          // A read spends one extra cycle in ACK while the word moves into
          // the output register; the ack is raised alongside it.
          if (rd_pend) begin
            rd_pend <= 1'b0;
            ack_q   <= 1'b1;
            data_q  <= ram_rdata;
          end else begin
            ack_q   <= 1'b0;
            data_q  <= '0;
            state   <= ST_IDLE;
          end
`else
          ack_q <= 1'b0;
          state <= ST_IDLE;
`endif
        end
        default: state <= ST_IDLE;
      endcase

      if (ram_en) begin
`ifdef WBRAM_READ_REG_EN
        if (ram_wr) ack_q   <= 1'b1;
        else        rd_pend <= 1'b1;
`else
        ack_q <= 1'b1;
`endif
      end
    end
  end

  assign wishbone_ack_o = ack_q;
`ifdef WBRAM_READ_REG_EN
  assign wishbone_data_o = data_q;
`else
  assign wishbone_data_o = ack_q ? ram_rdata : '0;
`endif

endmodule
